// File: rtl/pm_norm_bank_pkg.sv
// Shared definitions for the path-metric normalization bank.
// Optional feature macro: PM_NORM_CNT_EN (adds the 16-bit norm_cnt output).
package pm_pkg;

  localparam int PM_W_DEF       = 7;
  localparam int ID_W_DEF       = 4;
  localparam int NUM_STATES_DEF = 4;

  // Bit position of the metric MSB used for normalization
  function automatic int norm_bit_of(input int pm_w);
    return pm_w - 1;
  endfunction

  localparam int NORM_BIT = norm_bit_of(PM_W_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pm_state_t;

endpackage

// File: rtl/pm_norm_bank_if.sv
// Handshake/data bundle between the ACS array, the bank and the next trellis stage.
// Optional feature macro: PM_NORM_CNT_EN (norm_cnt is a plain top-level port).
interface pm_norm_bank_if
  import pm_pkg::*;
#(
  parameter int NUM_STATES = NUM_STATES_DEF,
  parameter int PM_W       = PM_W_DEF,
  parameter int ID_W       = ID_W_DEF
);

  logic                       in_valid;
  logic                       in_ready;
  logic                       start;
  logic [ID_W-1:0]            data_id;
  logic [NUM_STATES*PM_W-1:0] PM_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_STATES*PM_W-1:0] PM_out;
  logic [ID_W-1:0]            data_id_out;
  logic                       norm_flag;
  logic                       id_err;

  modport master (
    output in_valid, start, data_id, PM_in, out_ready,
    input  in_ready, out_valid, PM_out, data_id_out, norm_flag, id_err
  );

  modport slave (
    input  in_valid, start, data_id, PM_in, out_ready,
    output in_ready, out_valid, PM_out, data_id_out, norm_flag, id_err
  );

endinterface

// File: rtl/pm_norm_bank_normalizer.sv
// Combinational MSB normalizer: when every metric has its MSB set, all MSBs
// are cleared, which is an exact subtraction of 2^(PM_W-1) from each metric.
// Optional feature macro: PM_NORM_CNT_EN (not used here).
module pm_normalizer
  import pm_pkg::*;
#(
  parameter int NUM_STATES = NUM_STATES_DEF,
  parameter int PM_W       = PM_W_DEF
) (
  input  logic [NUM_STATES*PM_W-1:0] pm_in,
  output logic [NUM_STATES*PM_W-1:0] pm_out,
  output logic                       norm_flag
);

  localparam int MSB_IDX = norm_bit_of(PM_W);

  // Detect the all-MSB-set condition and strip the MSBs when it holds
  always_comb begin
    norm_flag = 1'b1;
    pm_out    = pm_in;
    for (int s = 0; s < NUM_STATES; s++) begin
      norm_flag = norm_flag & pm_in[s*PM_W + MSB_IDX];
    end
    if (norm_flag) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm_out[s*PM_W + MSB_IDX] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pm_norm_bank.sv
// One-deep path-metric register bank with valid/ready handshake, MSB
// normalization on the load path and in-order data_id checking.
// Optional feature macro: PM_NORM_CNT_EN (adds norm_cnt, saturating count of
// normalized symbols since the last accepted start).
module pm_norm_bank
  import pm_pkg::*;
#(
  parameter int NUM_STATES = NUM_STATES_DEF,
  parameter int PM_W       = PM_W_DEF,
  parameter int ID_W       = ID_W_DEF
) (
  input  logic        PM_clk,
  input  logic        PM_rst,
  pm_norm_bank_if.slave bus
`ifdef PM_NORM_CNT_EN
  ,
  output logic [15:0] norm_cnt
`endif
);

  pm_state_t                  state;
  logic [ID_W-1:0]            exp_id;
  logic [NUM_STATES*PM_W-1:0] norm_vec;
  logic                       norm_hit;
  logic                       accept;

  pm_normalizer #(
    .NUM_STATES(NUM_STATES),
    .PM_W      (PM_W)
  ) u_normalizer (
    .pm_in    (bus.PM_in),
    .pm_out   (norm_vec),
    .norm_flag(norm_hit)
  );

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Output register, frame FSM and sticky id sequence check
  always_ff @(posedge PM_clk or negedge PM_rst) begin
    if (!PM_rst) begin
      state           <= IDLE;
      exp_id          <= '0;
      bus.out_valid   <= 1'b0;
      bus.PM_out      <= '0;
      bus.data_id_out <= '0;
      bus.norm_flag   <= 1'b0;
      bus.id_err      <= 1'b0;
    end else if (accept) begin
      bus.out_valid   <= 1'b1;
      bus.PM_out      <= norm_vec;
      bus.data_id_out <= bus.data_id;
      bus.norm_flag   <= norm_hit;
      if (bus.start) begin
        state      <= RUN;
        exp_id     <= bus.data_id + ID_W'(1);
        bus.id_err <= 1'b0;
      end else if (state == IDLE) begin
        bus.id_err <= 1'b1;
      end else begin
        if (bus.data_id != exp_id) begin
          bus.id_err <= 1'b1;
        end
        exp_id <= bus.data_id + ID_W'(1);
      end
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef PM_NORM_CNT_EN
  // Saturating count of normalized symbols, restarted by each accepted start
  always_ff @(posedge PM_clk or negedge PM_rst) begin
    if (!PM_rst) begin
      norm_cnt <= '0;
    end else if (accept) begin
      if (bus.start) begin
        norm_cnt <= norm_hit ? 16'd1 : 16'd0;
      end else if (norm_hit && norm_cnt != 16'hFFFF) begin
        norm_cnt <= norm_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pm_norm_bank.sv
// Scoreboard testbench for pm_norm_bank: the driver pushes the expected
// response from a behavioural model on every accepted symbol, a separate
// monitor compares whatever the bank presents on its output.
// Optional feature macro: PM_NORM_CNT_EN (norm_cnt is also scored).
module tb_pm_norm_bank;
  import pm_pkg::*;

  localparam int NS   = NUM_STATES_DEF;
  localparam int PW   = PM_W_DEF;
  localparam int IW   = ID_W_DEF;
  localparam int HALF = 1 << NORM_BIT;
  localparam int FULL = 1 << PW;
  localparam int IDS  = 1 << IW;

  typedef struct {
    logic [NS*PW-1:0] pm;
    logic [IW-1:0]    id;
    logic             nf;
    logic             err;
    logic [15:0]      cnt;
  } exp_t;

  logic PM_clk;
  logic PM_rst;
  int   checks;
  int   errors;
  int   bp_mode;
  exp_t q[$];

  bit   m_in_frame;
  int   m_next;
  bit   m_err;
  int   m_cnt;

  pm_norm_bank_if #(.NUM_STATES(NS), .PM_W(PW), .ID_W(IW)) bus ();

`ifdef PM_NORM_CNT_EN
  logic [15:0] norm_cnt;
`endif

  pm_norm_bank #(.NUM_STATES(NS), .PM_W(PW), .ID_W(IW)) dut (
    .PM_clk(PM_clk),
    .PM_rst(PM_rst),
    .bus   (bus.slave)
`ifdef PM_NORM_CNT_EN
    ,
    .norm_cnt(norm_cnt)
`endif
  );

  initial PM_clk = 1'b0;
  always #5 PM_clk = ~PM_clk;

  // Downstream ready: held high, held low, or random backpressure
  always @(posedge PM_clk) begin
    #1;
    case (bp_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check1("pm_out", 32'(bus.PM_out), 32'(e.pm));
    check1("data_id_out", 32'(bus.data_id_out), 32'(e.id));
    check1("norm_flag", 32'(bus.norm_flag), 32'(e.nf));
    check1("id_err", 32'(bus.id_err), 32'(e.err));
`ifdef PM_NORM_CNT_EN
    check1("norm_cnt", 32'(norm_cnt), 32'(e.cnt));
`endif
  endtask

  // Monitor: compare the held symbol every cycle, retire it when consumed
  always @(negedge PM_clk) begin
    if (PM_rst && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output actual=id %0h expected=none at %0t",
                 bus.data_id_out, $time);
      end else begin
        checkOutput(q[0]);
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  function automatic logic [NS*PW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [NS*PW-1:0] v;
    v = '0;
    v[0*PW +: PW] = PW'(a);
    v[1*PW +: PW] = PW'(b);
    v[2*PW +: PW] = PW'(c);
    v[3*PW +: PW] = PW'(d);
    return v;
  endfunction

  task automatic modelReset();
    m_in_frame = 1'b0;
    m_next     = 0;
    m_err      = 1'b0;
    m_cnt      = 0;
  endtask

  // Reference model: arithmetic on metric values plus frame/sequence rules
  task automatic modelPush(input bit st, input int id, input logic [NS*PW-1:0] pm);
    exp_t e;
    int   v[NS];
    bit   all_hi;
    all_hi = 1'b1;
    for (int s = 0; s < NS; s++) begin
      v[s] = int'(pm[s*PW +: PW]);
      if (v[s] < HALF) all_hi = 1'b0;
    end
    e.pm = '0;
    for (int s = 0; s < NS; s++) begin
      e.pm[s*PW +: PW] = PW'(all_hi ? v[s] - HALF : v[s]);
    end
    if (st) begin
      m_in_frame = 1'b1;
      m_err      = 1'b0;
      m_next     = (id + 1) % IDS;
      m_cnt      = all_hi ? 1 : 0;
    end else begin
      if (!m_in_frame) begin
        m_err = 1'b1;
      end else begin
        if (id != m_next) m_err = 1'b1;
        m_next = (id + 1) % IDS;
      end
      if (all_hi && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    e.id  = IW'(id);
    e.nf  = all_hi;
    e.err = m_err;
    e.cnt = 16'(m_cnt);
    q.push_back(e);
  endtask

  // Present one symbol (called at posedge+1), wait for acceptance, record it
  task automatic applyStimulus(input bit st, input int id, input logic [NS*PW-1:0] pm);
    int waited;
    bus.in_valid = 1'b1;
    bus.start    = st;
    bus.data_id  = IW'(id);
    bus.PM_in    = pm;
    waited       = 0;
    forever begin
      @(negedge PM_clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout actual=in_ready 0 expected=in_ready 1 at %0t", $time);
        break;
      end
    end
    if (bus.in_ready) modelPush(st, id, pm);
    @(posedge PM_clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    repeat (n) begin
      @(posedge PM_clk);
      #1;
    end
  endtask

  function automatic logic [NS*PW-1:0] randMetrics();
    logic [NS*PW-1:0] v;
    bit               hi;
    v  = '0;
    hi = ($urandom_range(0, 2) == 0);
    for (int s = 0; s < NS; s++) begin
      v[s*PW +: PW] = hi ? PW'($urandom_range(HALF, FULL - 1)) : PW'($urandom_range(0, FULL - 1));
    end
    return v;
  endfunction

  initial begin
    int waited;
    checks       = 0;
    errors       = 0;
    bp_mode      = 0;
    PM_rst       = 1'b0;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.data_id  = '0;
    bus.PM_in    = '0;
    bus.out_ready = 1'b1;
    modelReset();

    repeat (3) @(posedge PM_clk);
    @(negedge PM_clk);
    PM_rst = 1'b1;
    @(negedge PM_clk);
    check1("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check1("rst_pm_out", 32'(bus.PM_out), 32'd0);
    check1("rst_data_id_out", 32'(bus.data_id_out), 32'd0);
    check1("rst_norm_flag", 32'(bus.norm_flag), 32'd0);
    check1("rst_id_err", 32'(bus.id_err), 32'd0);
    check1("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PM_NORM_CNT_EN
    check1("rst_norm_cnt", 32'(norm_cnt), 32'd0);
`endif
    @(posedge PM_clk);
    #1;

    $display("[TB] directed frame, normalization and id sequencing");
    applyStimulus(1'b1, 3, pk(10, 20, 30, 40));
    applyStimulus(1'b0, 4, pk(1, 2, 3, 4));
    applyStimulus(1'b0, 5, pk(64, 70, 100, 127));
    applyStimulus(1'b0, 6, pk(64, 10, 100, 127));
    applyStimulus(1'b0, 8, pk(5, 6, 7, 8));
    applyStimulus(1'b0, 9, pk(99, 88, 77, 66));
    idle(2);
    applyStimulus(1'b1, 14, pk(11, 12, 13, 14));
    applyStimulus(1'b0, 15, pk(65, 66, 67, 68));
    applyStimulus(1'b0, 0, pk(1, 100, 1, 100));
    applyStimulus(1'b0, 1, pk(127, 127, 127, 127));
    idle(3);

    $display("[TB] backpressure hold and release");
    bp_mode = 1;
    idle(2);
    applyStimulus(1'b0, 2, pk(20, 21, 22, 23));
    bus.in_valid = 1'b1;
    bus.start    = 1'b0;
    bus.data_id  = IW'(3);
    bus.PM_in    = pk(30, 31, 32, 33);
    repeat (3) begin
      @(negedge PM_clk);
      check1("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bp_mode = 0;
    @(posedge PM_clk);
    #1;
    applyStimulus(1'b0, 3, pk(30, 31, 32, 33));
    applyStimulus(1'b0, 4, pk(70, 80, 90, 100));
    applyStimulus(1'b0, 5, pk(40, 41, 42, 43));
    applyStimulus(1'b0, 6, pk(50, 51, 52, 53));
    idle(3);

    $display("[TB] randomized traffic");
    bp_mode = 2;
    for (int i = 0; i < 200; i++) begin
      bit st;
      int id;
      st = ($urandom_range(0, 9) == 0);
      id = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, IDS - 1)) : m_next;
      applyStimulus(st, id, randMetrics());
      if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(1, 3)));
    end
    bp_mode = 0;
    idle(2);
    waited = 0;
    while (q.size() != 0 && waited < 100) begin
      @(posedge PM_clk);
      waited++;
    end
    #1;
    check1("drain_queue_empty", 32'(q.size()), 32'd0);
    check1("drain_out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] asynchronous reset with a held symbol");
    bp_mode = 1;
    idle(2);
    applyStimulus(1'b1, 7, pk(90, 91, 92, 93));
    bus.in_valid = 1'b0;
    check1("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    PM_rst = 1'b0;
    #1;
    check1("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check1("async_rst_pm_out", 32'(bus.PM_out), 32'd0);
    check1("async_rst_data_id_out", 32'(bus.data_id_out), 32'd0);
    q.delete();
    modelReset();
    @(negedge PM_clk);
    PM_rst  = 1'b1;
    bp_mode = 0;
    @(posedge PM_clk);
    #1;

    $display("[TB] normalized-symbol counting");
    idle(1);
    applyStimulus(1'b1, 0, pk(64, 65, 66, 67));
    applyStimulus(1'b0, 1, pk(100, 110, 120, 127));
    applyStimulus(1'b0, 2, pk(127, 64, 64, 64));
    applyStimulus(1'b0, 3, pk(1, 64, 64, 64));
    applyStimulus(1'b1, 9, pk(80, 81, 82, 83));
    idle(4);
    check1("final_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
